// File: rtl/gpio_exp_pkg.sv
// Shared definitions for the SPI-controlled GPIO expander: register map,
// frame geometry and frame FSM states.
package gpio_exp_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;

  // Base addresses; addr[0] selects the byte lane within a 16-bit register.
  localparam logic [ADDR_W-1:0] ADDR_DIR      = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_IN       = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 7'h08;
  localparam logic [ADDR_W-1:0] ADDR_ID       = 7'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } frame_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for asynchronous inputs, with a
// per-bit reset value so idle-high lines come out of reset inactive.
module gpio_sync #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gpio_expander_core.sv
// SPI-controlled GPIO expander: 16-bit mode-0 frames access DIR/OUT/IN/
// IRQ_EN/IRQ_STAT/ID registers; interrupt-on-change with W1C status.
module gpio_expander_core
  import gpio_exp_pkg::*;
#(
  parameter int unsigned N_PINS      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  logic [2:0]        w_spi_s;
  logic              w_sclk, w_cs_n, w_mosi;
  logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic [N_PINS-1:0] w_gpio_s;

  logic              r_sclk_d, r_cs_n_d;
  frame_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [FRAME_BITS-1:0] r_frame;
  logic [7:0]        r_miso_sr;
  logic              r_miso, r_miso_oe, r_irq;
  logic [N_PINS-1:0] r_dir, r_out, r_irq_en, r_irq_stat, r_gpio_prev;

  logic              w_load_rd, w_commit, w_shift_en, w_miso_shift;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  logic [15:0]       w_rd_reg16, w_lane_mask16, w_wdata16;
  logic [7:0]        w_rd_byte;
  logic [N_PINS-1:0] w_wmask, w_wdata, w_w1c, w_change;
  logic              w_wr_dir, w_wr_out, w_wr_en, w_wr_stat;

  // SPI lines share one synchroniser; cs_n idles high through reset.
  gpio_sync #(
    .WIDTH    (3),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(3'b010)
  ) u_spi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  ({spi_sclk, spi_cs_n, spi_mosi}),
    .o_q  (w_spi_s)
  );

  gpio_sync #(
    .WIDTH    (N_PINS),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL('0)
  ) u_gpio_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (gpio_in),
    .o_q  (w_gpio_s)
  );

  assign w_sclk      = w_spi_s[2];
  assign w_cs_n      = w_spi_s[1];
  assign w_mosi      = w_spi_s[0];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs_n & r_cs_n_d;
  assign w_cs_rise   = w_cs_n & ~r_cs_n_d;

  assign w_shift_en = w_sclk_rise &&
                      ((r_state == CMD  && r_bit_cnt < CNT_W'(CMD_BITS)) ||
                       (r_state == DATA && r_bit_cnt < CNT_W'(FRAME_BITS)));
  // Data-phase MISO shifts only after the first data rise; MSB is preloaded.
  assign w_miso_shift = w_sclk_fall && r_state == DATA &&
                        r_bit_cnt > CNT_W'(CMD_BITS) && r_bit_cnt < CNT_W'(FRAME_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_rd   = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: if (w_cs_fall) w_state_nxt = CMD;
      CMD: begin
        if (r_bit_cnt == CNT_W'(CMD_BITS)) begin
          w_state_nxt = DATA;
          w_load_rd   = ~r_frame[7];
        end
      end
      DATA: begin
        if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
          w_state_nxt = DONE;
          w_commit    = r_frame[15];
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = IDLE;
  end

  // Read mux: lane 1 of narrow builds reads 0 through zero extension.
  assign w_rd_addr = r_frame[6:0];
  always_comb begin
    w_rd_reg16 = '0;
    case (w_rd_addr[6:1])
      ADDR_DIR[6:1]:      w_rd_reg16 = 16'(r_dir);
      ADDR_OUT[6:1]:      w_rd_reg16 = 16'(r_out);
      ADDR_IN[6:1]:       w_rd_reg16 = 16'(w_gpio_s);
      ADDR_IRQ_EN[6:1]:   w_rd_reg16 = 16'(r_irq_en);
      ADDR_IRQ_STAT[6:1]: w_rd_reg16 = 16'(r_irq_stat);
      ADDR_ID[6:1]:       w_rd_reg16 = {8'h00, ID_VALUE};
      default:            w_rd_reg16 = '0;
    endcase
  end
  assign w_rd_byte = w_rd_addr[0] ? w_rd_reg16[15:8] : w_rd_reg16[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d  <= 1'b0;
      r_cs_n_d  <= 1'b1;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_miso_sr <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else begin
      r_sclk_d  <= w_sclk;
      r_cs_n_d  <= w_cs_n;
      r_miso_oe <= ~w_cs_n;
      if (w_cs_fall) begin
        r_bit_cnt <= '0;
        r_frame   <= '0;
      end else if (w_shift_en) begin
        r_frame   <= {r_frame[14:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_cs_fall) begin
        r_miso    <= 1'b0;
        r_miso_sr <= '0;
      end else if (w_load_rd) begin
        r_miso    <= w_rd_byte[7];
        r_miso_sr <= {w_rd_byte[6:0], 1'b0};
      end else if (w_miso_shift) begin
        r_miso    <= r_miso_sr[7];
        r_miso_sr <= {r_miso_sr[6:0], 1'b0};
      end
    end
  end

  // Write decode: the lane mask confines a byte write to pins that exist.
  assign w_wr_addr     = r_frame[14:8];
  assign w_lane_mask16 = w_wr_addr[0] ? 16'hFF00 : 16'h00FF;
  assign w_wdata16     = w_wr_addr[0] ? {r_frame[7:0], 8'h00} : {8'h00, r_frame[7:0]};
  assign w_wmask       = N_PINS'(w_lane_mask16);
  assign w_wdata       = N_PINS'(w_wdata16) & w_wmask;
  assign w_wr_dir      = w_commit && (w_wr_addr[6:1] == ADDR_DIR[6:1]);
  assign w_wr_out      = w_commit && (w_wr_addr[6:1] == ADDR_OUT[6:1]);
  assign w_wr_en       = w_commit && (w_wr_addr[6:1] == ADDR_IRQ_EN[6:1]);
  assign w_wr_stat     = w_commit && (w_wr_addr[6:1] == ADDR_IRQ_STAT[6:1]);
  assign w_w1c         = w_wr_stat ? w_wdata : '0;
  assign w_change      = w_gpio_s ^ r_gpio_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir       <= '0;
      r_out       <= '0;
      r_irq_en    <= '0;
      r_irq_stat  <= '0;
      r_gpio_prev <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_dir) r_dir    <= (r_dir & ~w_wmask) | w_wdata;
      if (w_wr_out) r_out    <= (r_out & ~w_wmask) | w_wdata;
      if (w_wr_en)  r_irq_en <= (r_irq_en & ~w_wmask) | w_wdata;
      // A new change event overrides a simultaneous clear.
      r_irq_stat  <= (r_irq_stat & ~w_w1c) | (w_change & r_irq_en);
      r_gpio_prev <= w_gpio_s;
      r_irq       <= |r_irq_stat;
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign gpio_out    = r_out;
  assign gpio_oe     = r_dir;
  assign irq         = r_irq;

endmodule
